// File: rtl/i2s_rx.sv
// I2S receive deserializer: synchronizes BCLK/LRCLK/SDATA, assembles 24-bit L/R pairs
// and presents them on a valid/ready port. Optional peak meter enabled by I2S_RX_PEAK_EN.
module i2s_rx #(
    parameter int WIDTH       = 24,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             bclk_i,
    input  logic             lrclk_i,
    input  logic             sdata_i,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_l,
    output logic [WIDTH-1:0] out_r,
    output logic             overrun,
    output logic             frame_err,
    output logic [7:0]       peak
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, PAD} state_t;

    logic [SYNC_STAGES-1:0] bclk_sync_q, bclk_sync_d;
    logic [SYNC_STAGES-1:0] lr_sync_q, lr_sync_d;
    logic [SYNC_STAGES-1:0] sd_sync_q, sd_sync_d;
    logic                   bclk_prev_q, bclk_prev_d;
    logic                   primed_q, primed_d;
    logic                   lr_prev_q, lr_prev_d;
    state_t                 state_q, state_d;
    logic                   chan_q, chan_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [WIDTH-1:0]       shreg_q, shreg_d;
    logic [WIDTH-1:0]       hold_l_q, hold_l_d;
    logic                   have_l_q, have_l_d;
    logic                   out_valid_q, out_valid_d;
    logic [WIDTH-1:0]       out_l_q, out_l_d;
    logic [WIDTH-1:0]       out_r_q, out_r_d;
    logic                   overrun_q, overrun_d;
    logic                   frame_err_q, frame_err_d;

    logic             bclk_s, lr_s, sd_s, rise, slot_start, word_done, load;
    logic [WIDTH-1:0] word;

    assign bclk_s     = bclk_sync_q[SYNC_STAGES-1];
    assign lr_s       = lr_sync_q[SYNC_STAGES-1];
    assign sd_s       = sd_sync_q[SYNC_STAGES-1];
    assign rise       = bclk_s & ~bclk_prev_q;
    // The first rise after reset only primes lr_prev, so a slot already in progress is never taken as a start.
    assign slot_start = rise & primed_q & (lr_s != lr_prev_q);
    assign word       = {shreg_q[WIDTH-2:0], sd_s};

    always_comb begin
        bclk_sync_d = {bclk_sync_q[SYNC_STAGES-2:0], bclk_i};
        lr_sync_d   = {lr_sync_q[SYNC_STAGES-2:0], lrclk_i};
        sd_sync_d   = {sd_sync_q[SYNC_STAGES-2:0], sdata_i};
        bclk_prev_d = bclk_s;
        primed_d    = primed_q;
        lr_prev_d   = lr_prev_q;
        state_d     = state_q;
        chan_d      = chan_q;
        cnt_d       = cnt_q;
        shreg_d     = shreg_q;
        hold_l_d    = hold_l_q;
        have_l_d    = have_l_q;
        out_valid_d = out_valid_q;
        out_l_d     = out_l_q;
        out_r_d     = out_r_q;
        overrun_d   = 1'b0;
        frame_err_d = frame_err_q;
        word_done   = 1'b0;
        load        = 1'b0;

        if (rise) begin
            primed_d  = 1'b1;
            lr_prev_d = lr_s;
            if (slot_start) begin
                if (state_q == SHIFT)
                    frame_err_d = 1'b1;
                chan_d  = lr_s;
                cnt_d   = '0;
                state_d = SHIFT;
            end else if (state_q == SHIFT) begin
                shreg_d = word;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    word_done = 1'b1;
                    state_d   = PAD;
                end
            end
        end

        if (word_done) begin
            if (!chan_q) begin
                hold_l_d = word;
                have_l_d = 1'b1;
            end else begin
                have_l_d = 1'b0;
                load     = have_l_q;
            end
        end

        if (load) begin
            out_l_d     = hold_l_q;
            out_r_d     = word;
            out_valid_d = 1'b1;
            overrun_d   = out_valid_q & ~out_ready;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bclk_sync_q <= '0;
            lr_sync_q   <= '0;
            sd_sync_q   <= '0;
            bclk_prev_q <= 1'b0;
            primed_q    <= 1'b0;
            lr_prev_q   <= 1'b0;
            state_q     <= IDLE;
            chan_q      <= 1'b0;
            cnt_q       <= '0;
            shreg_q     <= '0;
            hold_l_q    <= '0;
            have_l_q    <= 1'b0;
            out_valid_q <= 1'b0;
            out_l_q     <= '0;
            out_r_q     <= '0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            bclk_sync_q <= bclk_sync_d;
            lr_sync_q   <= lr_sync_d;
            sd_sync_q   <= sd_sync_d;
            bclk_prev_q <= bclk_prev_d;
            primed_q    <= primed_d;
            lr_prev_q   <= lr_prev_d;
            state_q     <= state_d;
            chan_q      <= chan_d;
            cnt_q       <= cnt_d;
            shreg_q     <= shreg_d;
            hold_l_q    <= hold_l_d;
            have_l_q    <= have_l_d;
            out_valid_q <= out_valid_d;
            out_l_q     <= out_l_d;
            out_r_q     <= out_r_d;
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_l     = out_l_q;
    assign out_r     = out_r_q;
    assign overrun   = overrun_q;
    assign frame_err = frame_err_q;

`ifdef I2S_RX_PEAK_EN
    logic [7:0]       peak_q, peak_d;
    logic [WIDTH-1:0] mag;
    logic [7:0]       word_pk;

    always_comb begin
        mag     = word[WIDTH-1] ? (~word + WIDTH'(1)) : word;
        // Only the most-negative code still has its MSB set after negation; it saturates.
        word_pk = mag[WIDTH-1] ? 8'hFF : mag[WIDTH-1:WIDTH-8];
        peak_d  = peak_q;
        if (out_valid_q && out_ready)
            peak_d = word_done ? word_pk : 8'h00;
        else if (word_done && (word_pk > peak_q))
            peak_d = word_pk;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            peak_q <= 8'h00;
        else
            peak_q <= peak_d;
    end

    assign peak = peak_q;
`else
    assign peak = 8'h00;
`endif

endmodule

// File: tb/tb_i2s_rx.sv
// Randomized bench for i2s_rx: an I2S codec model drives the pins, a frame-level
// reference predicts out_valid/out_l/out_r/overrun/frame_err cycle by cycle.
module tb_i2s_rx;
    localparam int W = 24;
    localparam int S = 2;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         bclk_i = 1'b0;
    logic         lrclk_i = 1'b0;
    logic         sdata_i = 1'b0;
    logic         out_ready = 1'b1;
    logic         out_valid, overrun, frame_err;
    logic [W-1:0] out_l, out_r;
    logic [7:0]   peak;

    i2s_rx #(.WIDTH(W), .SYNC_STAGES(S)) dut (
        .clk(clk), .rst(rst), .bclk_i(bclk_i), .lrclk_i(lrclk_i), .sdata_i(sdata_i),
        .out_valid(out_valid), .out_ready(out_ready), .out_l(out_l), .out_r(out_r),
        .overrun(overrun), .frame_err(frame_err), .peak(peak)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] l;
        logic [W-1:0] r;
        int           c;
    } frm_t;

    frm_t         fq[$];
    int           total = 0;
    int           bad = 0;
    int           cyc = 0;
    int           err_cyc = -1;
    int           last_load_cyc = -10;
    int           ready_mode = 0;
    int           ovr_cnt = 0;
    logic         mdl_have_l = 1'b0;
    logic [W-1:0] mdl_l = '0;
    logic         short_pend = 1'b0;
    logic [W-1:0] seen_l = '0, seen_r = '0;
    logic         exp_valid = 1'b0, exp_ovr = 1'b0, exp_err = 1'b0;
    logic [W-1:0] exp_l = '0, exp_r = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // One I2S slot: bit 0 is the one-BCLK delay bit, bits 1..W the word MSB first, the rest pad.
    task automatic send_slot(input logic ch, input logic [W-1:0] w, input int nb);
        logic counted;
        counted = !rst;
        for (int k = 0; k < nb; k++) begin
            bclk_i  = 1'b0;
            lrclk_i = ch;
            sdata_i = (k >= 1 && k <= W) ? w[W-k] : 1'($urandom);
            #50;
            bclk_i = 1'b1;
            if (counted) begin
                if (k == 0 && short_pend) begin
                    err_cyc    = cyc + 1 + S;
                    short_pend = 1'b0;
                end
                if (k == W) begin
                    if (!ch) begin
                        mdl_have_l = 1'b1;
                        mdl_l      = w;
                    end else begin
                        if (mdl_have_l) begin
                            fq.push_back('{mdl_l, w, cyc + 1 + S});
                            last_load_cyc = cyc + 1 + S;
                        end
                        mdl_have_l = 1'b0;
                    end
                end
            end
            #50;
        end
        if (counted && nb < W + 1)
            short_pend = 1'b1;
    endtask

    task automatic send_frame(input logic [W-1:0] l, input logic [W-1:0] r);
        send_slot(1'b0, l, 32);
        send_slot(1'b1, r, 32);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Reference model update on each posedge, comparison on the following negedge.
    initial begin
        frm_t f;
        forever begin
            @(posedge clk);
            cyc++;
            if (rst) begin
                exp_valid = 1'b0; exp_ovr = 1'b0; exp_err = 1'b0;
                exp_l = '0; exp_r = '0;
            end else begin
                exp_ovr = 1'b0;
                if (cyc == err_cyc)
                    exp_err = 1'b1;
                if (fq.size() > 0 && fq[0].c == cyc) begin
                    f = fq.pop_front();
                    exp_ovr   = exp_valid && !out_ready;
                    exp_valid = 1'b1;
                    exp_l     = f.l;
                    exp_r     = f.r;
                end else if (exp_valid && out_ready) begin
                    exp_valid = 1'b0;
                end
            end
            @(negedge clk);
            chk("out_valid", 32'(out_valid), 32'(exp_valid));
            chk("overrun", 32'(overrun), 32'(exp_ovr));
            chk("frame_err", 32'(frame_err), 32'(exp_err));
            chk("out_l", 32'(out_l), 32'(exp_l));
            chk("out_r", 32'(out_r), 32'(exp_r));
`ifndef I2S_RX_PEAK_EN
            chk("peak_off", 32'(peak), 32'h0);
`endif
            if (out_valid) begin
                seen_l = out_l;
                seen_r = out_r;
            end
            if (overrun)
                ovr_cnt++;
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            case (ready_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'($urandom);
                2:       out_ready = 1'b0;
                default: out_ready = (cyc + 1 == last_load_cyc);
            endcase
        end
    end

    initial begin
        logic [W-1:0] a_l, a_r, b_l, b_r;
        idle(3);
        chk("reset_valid", 32'(out_valid), 32'h0);
        chk("reset_out_l", 32'(out_l), 32'h0);
        chk("reset_frame_err", 32'(frame_err), 32'h0);

        // Start-up: reset released in the middle of a right slot.
        send_slot(1'b0, 24'h55AA55, 32);
        fork
            send_slot(1'b1, 24'hC3C3C3, 32);
            begin #1000; rst = 1'b0; end
        join

        send_frame(24'h123456, 24'hABCDEF);
        idle(5);
        chk("stereo_l", 32'(seen_l), 32'h123456);
        chk("stereo_r", 32'(seen_r), 32'hABCDEF);
        chk("stereo_no_err", 32'(frame_err), 32'h0);

        ready_mode = 1;
        for (int i = 0; i < 10; i++)
            send_frame(W'($urandom), W'($urandom));

        // Backpressure across two frames.
        ready_mode = 0; idle(5);
        ready_mode = 2; ovr_cnt = 0;
        b_l = W'($urandom); b_r = W'($urandom);
        send_frame(W'($urandom), W'($urandom));
        send_frame(b_l, b_r);
        idle(5);
        chk("bp_overrun_once", 32'(ovr_cnt), 32'd1);
        chk("bp_valid", 32'(out_valid), 32'h1);
        chk("bp_l_is_b", 32'(out_l), 32'(b_l));
        chk("bp_r_is_b", 32'(out_r), 32'(b_r));

        // Accept exactly on the load cycle of frame B.
        ready_mode = 0; idle(5);
        ready_mode = 3; ovr_cnt = 0;
        a_l = W'($urandom); a_r = W'($urandom);
        b_l = W'($urandom); b_r = W'($urandom);
        send_frame(a_l, a_r);
        send_frame(b_l, b_r);
        idle(5);
        chk("sim_no_overrun", 32'(ovr_cnt), 32'd0);
        chk("sim_valid", 32'(out_valid), 32'h1);
        chk("sim_l_is_b", 32'(out_l), 32'(b_l));

        // Short left slot: 16 bits then LRCLK toggles.
        ready_mode = 0; idle(5);
        send_slot(1'b0, W'($urandom), 17);
        send_slot(1'b1, W'($urandom), 32);
        send_frame(24'h0F1E2D, 24'h3C4B5A);
        idle(5);
        chk("short_err_latched", 32'(frame_err), 32'h1);
        chk("short_next_l", 32'(seen_l), 32'h0F1E2D);
        chk("short_next_r", 32'(seen_r), 32'h3C4B5A);

`ifdef I2S_RX_PEAK_EN
        ready_mode = 2;
        send_frame(24'h7F0000, 24'h800000);
        idle(5);
        chk("peak_sat", 32'(peak), 32'hFF);
        ready_mode = 0; idle(5);
        ready_mode = 2;
        send_frame(24'h100000, 24'hF00000);
        idle(5);
        chk("peak_after_accept", 32'(peak), 32'h10);
        ready_mode = 0; idle(5);
`endif

        ready_mode = 1;
        for (int i = 0; i < 8; i++)
            send_frame(W'($urandom), W'($urandom));
        ready_mode = 0;
        idle(20);
        chk("queue_drained", 32'(fq.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/i2s_rx.md
# i2s_rx

Receive-side I2S deserializer for the audio codec ADC path. It samples the codec's serial bit clock, word clock and ADC data pins in the system clock domain. It reconstructs 24-bit left/right sample pairs and presents each stereo frame on a valid/ready port to the main module, for example for microphone/line-in capture or a loopback test. It is a passive slave: BCLK and LRCLK come from the transmit controller, which drives the codec, and this block only observes them.

## Interface
- `WIDTH`, 24: captured bits per channel, MSB first; further bits in the slot are ignored.
- `SYNC_STAGES`, 2: flip-flop depth of the input synchronizers; legal values are 2..4.
- `clk`  in  1  system clock (100 MHz); all logic is on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `bclk_i`  in  1  codec serial bit clock, asynchronous to `clk`.
- `lrclk_i`  in  1  codec word clock: 0 = left slot, 1 = right slot.
- `sdata_i`  in  1  codec ADC serial data (`ac_adc_sdata`).
- `out_valid`  out  1  a stereo frame is held in `out_l` / `out_r`.
- `out_ready`  in  1  consumer accepts the frame.
- `out_l`  out  WIDTH  left sample, two's complement.
- `out_r`  out  WIDTH  right sample, two's complement.
- `overrun`  out  1  one-cycle pulse when an unaccepted frame is overwritten.
- `frame_err`  out  1  sticky: a slot ended before WIDTH bits were captured. Cleared only by `rst`.
- `peak`  out  8  peak meter; present only with `I2S_RX_PEAK_EN`.

## Operation
- Synchronization:
  - `bclk_i`, `lrclk_i` and `sdata_i` each pass through `SYNC_STAGES` flip-flops, so all three share equal latency.
  - A BCLK rising edge (`rise`) is detected when the synced BCLK is 1 and its previous value was 0.
- On every `rise`, synced `lrclk` and `sdata` are sampled. `lr_prev` holds the LRCLK sampled at the previous `rise`.
- Slot start: a `rise` where `lrclk` differs from `lr_prev`.
  - That rise carries the I2S one-bit delay bit, which is discarded.
  - `chan <= lrclk`, `cnt <= 0`, state goes to SHIFT.
- States:
  - IDLE: the reset state. Wait for the first slot start. Any partial slot after reset is dropped.
  - SHIFT: on each `rise`, `shreg <= {shreg[WIDTH-2:0], sdata}` and `cnt++`. When the rise that captures bit `WIDTH-1` occurs, write `shreg` into `hold_l` or `hold_r` according to `chan`, and go to PAD.
  - PAD: ignore further bits until the next slot start, then go to SHIFT.
  - A slot start while in SHIFT, i.e. fewer than WIDTH bits captured: set `frame_err`, discard the word, and restart SHIFT for the new slot.
- Frame assembly:
  - `have_l` is set when a left word completes and cleared when a right word completes.
  - A completed right word with `have_l` = 1 forms a frame. A right word with no preceding left word is dropped and does not set `frame_err`.
- Output register, loaded when a frame forms:
  - `out_l <= hold_l`, `out_r <= new right word`, `out_valid <= 1`.
  - If `out_valid && !out_ready` at load time: the newest frame wins and `overrun` pulses for 1 cycle.
  - If `out_ready` is high on the same cycle as a load, the old frame is accepted, the new frame is loaded, `out_valid` stays 1, and there is no overrun.
  - Otherwise `out_valid && out_ready` gives `out_valid <= 0` on the next cycle.
- Values are passed through unaltered, with no sign manipulation.
- Reset values: `out_valid` = 0, `out_l` = 0, `out_r` = 0, `overrun` = 0, `frame_err` = 0, `peak` = 0, state = IDLE, `have_l` = 0. Reset mid-slot discards all partial data.

## Timing
- `clk` must be at least 8 × BCLK, which is satisfied at 64 × 48 kHz = 3.072 MHz.
- `rise` is detected `SYNC_STAGES` + 1 `clk` cycles after the BCLK pin edge.
- Latency from the `rise` that samples right bit `WIDTH-1` to `out_valid` = 1 is 1 `clk` cycle.
- `out_l`, `out_r` and `out_valid` are registered outputs, stable while `out_valid && !out_ready`.
- `overrun` and `out_valid` update on the same edge.

## Configuration
- `I2S_RX_PEAK_EN` defined:
  - `peak` holds the maximum of `|sample|[WIDTH-1:WIDTH-8]` over all left and right words completed since the last accepted frame. The most-negative value saturates to 0xFF.
  - `peak` clears to the current frame's value on each `out_valid && out_ready`.
- Undefined: `peak` is tied to 0 and no meter logic is synthesized.

## Test plan
- Stereo frame:
  - Stimulus: 64-BCLK frames, left = 0x123456, right = 0xABCDEF, MSB one BCLK after the LRCLK edge, `out_ready` = 1.
  - Required: `out_valid` pulses with `out_l` = 0x123456 and `out_r` = 0xABCDEF. `frame_err` stays 0.
- Start-up alignment:
  - Stimulus: release `rst` mid-right slot.
  - Required: the first `out_valid` carries the first complete left+right pair after release. No partial data appears.
- Backpressure:
  - Stimulus: hold `out_ready` = 0 across two frames A then B.
  - Required: `out_valid` stays 1, `overrun` pulses once when B loads, outputs equal B, and frame A never reappears.
- Simultaneous accept and load:
  - Stimulus: `out_ready` = 1 on exactly the cycle frame B loads.
  - Required: no overrun; `out_valid` stays 1 with B.
- Short slot:
  - Stimulus: toggle LRCLK after 16 bits of a left slot.
  - Required: `frame_err` = 1 and latches; the next full frame is still delivered correctly.
- Peak meter, with `I2S_RX_PEAK_EN`:
  - Stimulus: left = 0x7F0000, right = 0x800000.
  - Required: `peak` = 0xFF. With the next frame ±0x100000 after acceptance, `peak` = 0x10.
